div_share_ctrl: RTL and testbench

- Sequencing controller and arbiter that shares one iterative restoring divider between two requester ports (0 and 1).
- Each port issues numerator/denominator with a valid/ready handshake and receives quotient, remainder and a divide-by-zero flag with a valid/ready handshake.
- Arbitration is round-robin. The divider produces one quotient bit per clock using the shift/compare/subtract recurrence.
- Sits between switch/keypad front-ends and LED/segment display logic on the board.

---
 rtl/div_share_ctrl_if.sv | 27 ++
 rtl/div_share_ctrl.sv | 177 +++++++++++++++++
 tb/tb_div_share_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_share_ctrl_if.sv
// Request/response bundle for div_share_ctrl: two requester ports sharing one
// divider, with a shared result bus qualified by per-port rsp_valid.
interface div_share_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] numer0;
  logic [WIDTH-1:0] denom0;
  logic [WIDTH-1:0] numer1;
  logic [WIDTH-1:0] denom1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output req_valid, numer0, denom0, numer1, denom1, rsp_ready,
    input  req_ready, rsp_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  req_valid, numer0, denom0, numer1, denom1, rsp_ready,
    output req_ready, rsp_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin arbiter sharing one restoring divider (one quotient bit per clock)
// between two requester ports. Optional macro DIV_SHARE_DZ_CNT_EN enables dz_cnt.
module div_share_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  div_share_ctrl_if.slave  bus,
  output logic             busy,
  output logic [7:0]       dz_cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] denom_q, denom_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [CW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             grant_vld;
  logic             grant;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] sel_numer;
  logic [WIDTH-1:0] sel_denom;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_work;

  // Pointer port wins when valid; otherwise the other port may take the slot.
  always_comb begin
    grant_vld = 1'b0;
    grant     = ptr_q;
    if (bus.req_valid[ptr_q]) begin
      grant_vld = 1'b1;
      grant     = ptr_q;
    end else if (bus.req_valid[~ptr_q]) begin
      grant_vld = 1'b1;
      grant     = ~ptr_q;
    end
  end

  assign sel_numer = grant ? bus.numer1 : bus.numer0;
  assign sel_denom = grant ? bus.denom1 : bus.denom0;
  assign accept    = (state_q == IDLE) && grant_vld && !rst;
  assign rsp_hs    = (state_q == DONE) && bus.rsp_ready[owner_q];

  // work_q starts as the numerator and fills with quotient bits from the LSB.
  assign shifted   = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
  assign take      = (shifted >= {1'b0, denom_q});
  assign diff      = shifted - {1'b0, denom_q};
  assign step_rem  = take ? diff : shifted;
  assign step_work = {work_q[WIDTH-2:0], take};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    denom_d = denom_q;
    work_d  = work_q;
    prem_d  = prem_q;
    step_d  = step_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          denom_d = sel_denom;
          work_d  = sel_numer;
          prem_d  = '0;
          step_d  = '0;
          if (sel_denom == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = sel_numer;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = step_rem;
        work_d = step_work;
        step_d = step_q + CW'(1);
        if (step_q == LAST_STEP) begin
          state_d = DONE;
          quo_d   = step_work;
          rem_d   = step_rem[WIDTH-1:0];
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        if (rsp_hs) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      denom_q <= '0;
      work_q  <= '0;
      prem_q  <= '0;
      step_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      denom_q <= denom_d;
      work_q  <= work_d;
      prem_q  <= prem_d;
      step_q  <= step_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.req_ready = accept ? (2'b01 << grant) : '0;
  assign bus.rsp_valid = (state_q == DONE) ? (2'b01 << owner_q) : '0;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign busy          = (state_q != IDLE);

`ifdef DIV_SHARE_DZ_CNT_EN
  logic [7:0] dzc_q, dzc_d;

  // Counted at the request handshake, saturating at 255.
  always_comb begin
    dzc_d = dzc_q;
    if (accept && (sel_denom == '0) && (dzc_q != 8'hFF)) begin
      dzc_d = dzc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dzc_q <= '0;
    end else begin
      dzc_q <= dzc_d;
    end
  end

  assign dz_cnt = dzc_q;
`else
  assign dz_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl: directed scenarios plus a randomized-timing
// exhaustive sweep checked against plain integer division.
module tb_div_share_ctrl;
  localparam int unsigned W = 4;
  localparam logic [W-1:0] ONES = '1;
`ifdef DIV_SHARE_DZ_CNT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] dz_cnt;
  int         checks = 0;
  int         errors = 0;

  div_share_ctrl_if #(.WIDTH(W)) bus ();

  div_share_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .dz_cnt (dz_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_q(input int unsigned n, input int unsigned d);
    return (d == 0) ? ONES : W'(n / d);
  endfunction

  function automatic logic [W-1:0] ref_r(input int unsigned n, input int unsigned d);
    return (d == 0) ? W'(n) : W'(n % d);
  endfunction

  function automatic logic [7:0] dz_expect(input int unsigned events);
    return DZ_EN ? ((events > 255) ? 8'd255 : 8'(events)) : 8'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.numer0 = '0;
    bus.denom0 = '0;
    bus.numer1 = '0;
    bus.denom1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.denom0 = 4'd3;
    bus.denom1 = 4'd3;
    cyc();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready: got %b, expected 00", bus.req_ready);
    end
    cyc();
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00 || busy !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_zero !== 1'b0 || dz_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rsp_valid=%b busy=%b q=%0d r=%0d dz=%b cnt=%0d, expected all 0",
               bus.rsp_valid, busy, bus.quotient, bus.remainder, bus.div_zero, dz_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.req_valid = 2'b01;
    bus.numer0 = 4'd13;
    bus.denom0 = 4'd3;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got req_ready=%b busy=%b, expected 01/0", bus.req_ready, busy);
    end
    cyc();
    bus.req_valid = '0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || bus.rsp_valid !== ((k == W + 1) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL basic_timing T+%0d: got busy=%b rsp_valid=%b", k, busy, bus.rsp_valid);
      end
      if (k <= W) cyc();
    end
    checks++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1 || bus.div_zero !== 1'b0) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b, expected 4 1 0",
                         bus.quotient, bus.remainder, bus.div_zero);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL basic_release: got busy=%b rsp_valid=%b, expected 0/00", busy, bus.rsp_valid);
    end
  endtask

  task automatic test_simultaneous();
    int acc0 = -1, acc1 = -1;
    bit both = 0, got0 = 0, got1 = 0, order_bad = 0;
    logic clr0, clr1;
    logic [W-1:0] q0 = '0, r0 = '0, q1 = '0, r1 = '0;
    do_reset();
    bus.req_valid = 2'b11;
    bus.numer0 = 4'd15; bus.denom0 = 4'd4;
    bus.numer1 = 4'd9;  bus.denom1 = 4'd2;
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req_ready === 2'b11) both = 1;
      clr0 = bus.req_ready[0] & bus.req_valid[0];
      clr1 = bus.req_ready[1] & bus.req_valid[1];
      if (clr0) acc0 = c;
      if (clr1) acc1 = c;
      if (bus.rsp_valid === 2'b01 && !got0) begin
        got0 = 1; q0 = bus.quotient; r0 = bus.remainder;
        if (got1) order_bad = 1;
      end
      if (bus.rsp_valid === 2'b10 && !got1) begin
        got1 = 1; q1 = bus.quotient; r1 = bus.remainder;
        if (!got0) order_bad = 1;
      end
      if (got1) break;
      cyc();
      if (clr0) bus.req_valid[0] = 1'b0;
      if (clr1) bus.req_valid[1] = 1'b0;
    end
    cyc();
    idle_inputs();
    checks++;
    if (!got0 || !got1 || order_bad) begin
      errors++; $display("FAIL sim_order: got got0=%b got1=%b order_bad=%b, expected 1 1 0", got0, got1, order_bad);
    end
    checks++;
    if (acc0 != 0 || acc1 != int'(W + 2)) begin
      errors++; $display("FAIL sim_accept_cycles: got p0=%0d p1=%0d, expected 0 %0d", acc0, acc1, W + 2);
    end
    checks++;
    if (q0 !== 4'd3 || r0 !== 4'd3 || q1 !== 4'd4 || r1 !== 4'd1) begin
      errors++; $display("FAIL sim_results: got p0 %0d/%0d p1 %0d/%0d, expected 3/3 4/1", q0, r0, q1, r1);
    end
    checks++;
    if (both) begin
      errors++; $display("FAIL sim_req_ready_onehot: got both bits high, expected never");
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    bus.req_valid = 2'b10;
    bus.numer1 = 4'd7;
    bus.denom1 = 4'd0;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++; $display("FAIL dz_accept: got %b, expected 10", bus.req_ready);
    end
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.quotient !== ONES || bus.remainder !== 4'd7 || bus.div_zero !== 1'b1) begin
      errors++; $display("FAIL dz_result: got rsp_valid=%b q=%0d r=%0d dz=%b, expected 10 15 7 1",
                         bus.rsp_valid, bus.quotient, bus.remainder, bus.div_zero);
    end
    checks++;
    if (dz_cnt !== dz_expect(1)) begin
      errors++; $display("FAIL dz_count: got %0d, expected %0d", dz_cnt, dz_expect(1));
    end
    cyc();
    bus.rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL dz_release: got rsp_valid=%b busy=%b, expected 00/0", bus.rsp_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    bit bad = 0;
    do_reset();
    bus.req_valid = 2'b01;
    bus.numer0 = 4'd0;
    bus.denom0 = 4'd5;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_accept0: got %b, expected 01", bus.req_ready);
    end
    cyc();
    bus.req_valid = 2'b10;
    bus.numer1 = 4'd6;
    bus.denom1 = 4'd3;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) bad = 1;
      cyc();
    end
    // Response held 10 cycles while only the non-owner rsp_ready is high.
    for (int h = 0; h < 10; h++) begin
      bus.rsp_ready = 2'b10;
      @(negedge clk);
      if (bus.rsp_valid !== 2'b01 || bus.quotient !== 4'd0 || bus.remainder !== 4'd0 ||
          bus.div_zero !== 1'b0 || bus.req_ready !== 2'b00) bad = 1;
      cyc();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_hold: got unstable response or early accept, expected rsp_valid=01 q=0 r=0");
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL bp_handshake: got rsp_valid=%b req_ready=%b, expected 01/00", bus.rsp_valid, bus.req_ready);
    end
    cyc();
    bus.rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10 || bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL bp_next_accept: got req_ready=%b rsp_valid=%b, expected 10/00", bus.req_ready, bus.rsp_valid);
    end
    cyc();
    bus.req_valid = '0;
    repeat (W) cyc();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.quotient !== 4'd2 || bus.remainder !== 4'd0) begin
      errors++; $display("FAIL bp_p1_result: got rsp_valid=%b q=%0d r=%0d, expected 10 2 0",
                         bus.rsp_valid, bus.quotient, bus.remainder);
    end
    bus.rsp_ready = 2'b10;
    cyc();
    bus.rsp_ready = '0;
  endtask

  task automatic test_reset_mid_op();
    bit bad = 0;
    do_reset();
    bus.req_valid = 2'b01;
    bus.numer0 = 4'd12;
    bus.denom0 = 4'd5;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rmid_accept: got %b, expected 01", bus.req_ready);
    end
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rmid_busy: got %b, expected 1", busy);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_zero !== 1'b0 || dz_cnt !== 8'd0) begin
      errors++; $display("FAIL rmid_cleared: got busy=%b rsp_valid=%b q=%0d r=%0d, expected all 0",
                         busy, bus.rsp_valid, bus.quotient, bus.remainder);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rmid_no_response: got rsp_valid for abandoned op, expected none");
    end
    cyc();
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rmid_reaccept: got %b, expected 01", bus.req_ready);
    end
    cyc();
    bus.req_valid = '0;
    repeat (W) cyc();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.quotient !== 4'd2 || bus.remainder !== 4'd2) begin
      errors++; $display("FAIL rmid_result: got rsp_valid=%b q=%0d r=%0d, expected 01 2 2",
                         bus.rsp_valid, bus.quotient, bus.remainder);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_sweep();
    int unsigned n, d, lat, dly, gap, nzero;
    int p;
    logic [1:0] oh;
    logic [W-1:0] eq, er;
    bit ok;
    nzero = 0;
    do_reset();
    for (int unsigned idx = 0; idx < (1 << (2 * W)); idx++) begin
      n = idx % (1 << W);
      d = idx / (1 << W);
      p = int'(idx % 2);
      oh = 2'b01 << p;
      gap = $urandom_range(0, 2);
      dly = $urandom_range(0, 3);
      eq = ref_q(n, d);
      er = ref_r(n, d);
      repeat (gap + 1) cyc();
      bus.req_valid = oh;
      if (p == 0) begin
        bus.numer0 = W'(n); bus.denom0 = W'(d);
        bus.numer1 = W'($urandom); bus.denom1 = W'($urandom);
      end else begin
        bus.numer1 = W'(n); bus.denom1 = W'(d);
        bus.numer0 = W'($urandom); bus.denom0 = W'($urandom);
      end
      ok = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.req_ready === oh) begin ok = 1; break; end
        cyc();
      end
      checks++;
      if (!ok) begin
        errors++; $display("FAIL sweep_accept %0d/%0d port %0d: got no req_ready, expected %b", n, d, p, oh);
        return;
      end
      if (d == 0) nzero++;
      cyc();
      bus.req_valid = '0;
      lat = 1;
      ok = 0;
      for (int c = 0; c < int'(3 * W); c++) begin
        @(negedge clk);
        if (bus.rsp_valid !== 2'b00) begin ok = 1; break; end
        lat++;
        cyc();
      end
      checks++;
      if (!ok || lat != ((d == 0) ? 1 : W + 1) || bus.rsp_valid !== oh) begin
        errors++; $display("FAIL sweep_latency %0d/%0d: got lat=%0d rsp_valid=%b, expected %0d %b",
                           n, d, lat, bus.rsp_valid, (d == 0) ? 1 : W + 1, oh);
        if (!ok) return;
      end
      checks++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.div_zero !== (d == 0)) begin
        errors++; $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dz=%b, expected %0d %0d %b",
                           n, d, bus.quotient, bus.remainder, bus.div_zero, eq, er, d == 0);
      end
      for (int k = 0; k < int'(dly); k++) begin
        cyc();
        bus.rsp_ready = ~oh & 2'($urandom);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== oh || bus.quotient !== eq || bus.remainder !== er) begin
          errors++; $display("FAIL sweep_hold %0d/%0d: got rsp_valid=%b q=%0d r=%0d, expected %b %0d %0d",
                             n, d, bus.rsp_valid, bus.quotient, bus.remainder, oh, eq, er);
        end
      end
      cyc();
      bus.rsp_ready = oh | (~oh & 2'($urandom));
      @(negedge clk);
      cyc();
      bus.rsp_ready = '0;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++; $display("FAIL sweep_release %0d/%0d: got rsp_valid=%b busy=%b, expected 00 0",
                           n, d, bus.rsp_valid, busy);
      end
    end
    checks++;
    if (dz_cnt !== dz_expect(nzero)) begin
      errors++; $display("FAIL sweep_dz_count: got %0d, expected %0d", dz_cnt, dz_expect(nzero));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_simultaneous();
    test_div_zero();
    test_backpressure();
    test_reset_mid_op();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
